out_channel_buffer: RTL and testbench
=====================================

Name: out_channel_buffer

Overview:
- Downstream stage of the program interpreter's `out` instruction.
- Captures each word the interpreter emits (one-cycle strobe + data) into a small FIFO and streams it to the test harness over a valid/ready handshake.
- On the interpreter's finished pulse, drains the FIFO, then raises finished/success for the fpga test wrapper.

Parameters:
- MemoryElementWidth, 12, width of each output word
- NOut, 8, FIFO depth in words; power of two, minimum 2
- NExpected, 3, number of expected words checked (used only with OUT_CHECK_EN)
- Expected, {12'd1,12'd0,12'd3}, packed NExpected×MemoryElementWidth expected words; word 0 in the least significant slot

Ports:
- clock, input, 1, single clock; all state updates on the rising edge
- reset, input, 1, asynchronous, active-low: low resets immediately; release is synchronous to clock
- in_valid, input, 1, interpreter emitted a word this cycle
- in_data, input, MemoryElementWidth, word emitted by the interpreter
- prog_finished, input, 1, interpreter reached its default (halt) case; level or pulse
- out_valid, output, 1, out_data holds a word
- out_ready, input, 1, consumer accepts the word this cycle
- out_data, output, MemoryElementWidth, FIFO head word
- word_count, output, 16, words delivered downstream; saturates at 16'hFFFF
- overflow, output, 1, sticky: a word was dropped because the FIFO was full
- finished, output, 1, high once the drain is complete
- success, output, 1, valid when finished is high

Behaviour:
- Reset (reset low): all outputs 0; FIFO empty; read/write pointers 0; state RUN.
- FIFO storage: NOut words; pointers are log2(NOut)+1 bits wide.
  - Empty when the pointers are fully equal.
  - Full when the MSBs differ and the low bits are equal.
- Write: accepted when in_valid is high, state is RUN, and the FIFO is not full.
  - Full and no read this cycle: the word is dropped and overflow is set (sticky until reset).
  - Full and a read (out_valid && out_ready) in the same cycle: the write is accepted and the count is unchanged.
- Read: out_valid = not empty; out_data = mem[rd_ptr] (registered storage, combinational head).
  - Transfer occurs when out_valid && out_ready; rd_ptr increments and word_count increments.
  - No bypass: a word written in cycle N is visible on out_valid in cycle N+1 at the earliest.
  - Write and read in the same cycle on a FIFO with one word: the head is read, the new word becomes the head next cycle.
- Pointer wrap: modulo 2·NOut; words are delivered in strict emission order across wrap.
- out_data is stable while out_valid is high and out_ready is low (handshake hold rule).
- FSM states: RUN, DRAIN, DONE.
  - RUN: capture and stream. prog_finished high moves to DRAIN next cycle.
  - If in_valid and prog_finished are high in the same cycle, that word is still captured.
  - DRAIN: in_valid is ignored; no overflow set. FIFO empty (including on DRAIN entry) moves to DONE next cycle.
  - DONE: finished = 1 and success is latched; in_valid and prog_finished are ignored; holds until reset.
- Reset asserted mid-operation: immediate return to the reset state; buffered words are discarded.
- success when OUT_CHECK_EN is undefined: set in DONE as !overflow.

Optional Feature:
- Macro: OUT_CHECK_EN.
- Defined:
  - Each transferred word with index k < NExpected is compared against Expected[k].
  - A sticky mismatch flag is set on any difference.
  - success = !overflow && !mismatch && (word_count == NExpected) at DONE.
- Undefined:
  - No comparator and no Expected storage are synthesised; NExpected and Expected are unused.
  - success = !overflow at DONE.

Decomposition:
- Package out_channel_pkg holds:
  - typedef of the FSM state enum (RUN, DRAIN, DONE)
  - constant MemoryElementWidth default
  - function clog2 for pointer width
- One natural sub-module, out_fifo: storage, pointers, full/empty, simultaneous read/write rules.
- The parent holds the FSM, word_count, overflow, and the optional checker.

Test Plan:
- Emit 3, 0, 1 on consecutive cycles with out_ready high, then prog_finished:
  - out_data sequence 3, 0, 1, each one cycle after capture
  - word_count = 3; finished rises; with OUT_CHECK_EN and Expected = {1,0,3}, success = 1
- out_ready low, emit 9 words with NOut = 8, then release out_ready:
  - words 1–8 delivered in order; 9th dropped
  - overflow = 1; success = 0 at finished
- Fill to 8 words; in the next cycle emit a word while out_ready is high:
  - word accepted; no overflow; all 9 delivered in order
- prog_finished with 4 words buffered and out_ready toggling 1/0:
  - finished stays low until the 4th transfer, rises the cycle after empty
  - in_valid during DRAIN is ignored and word_count stays 4
- OUT_CHECK_EN, Expected = {1,0,3}, emit 3, 5, 1: mismatch at word 1 → success = 0 at finished.
- Assert reset low mid-stream with 5 words buffered:
  - out_valid, finished, overflow, word_count are 0 immediately, without a clock edge
  - after release, a fresh 3-word run passes

Source files
------------

// File: rtl/out_channel_buffer_pkg.sv
// Shared types and helpers for the out-channel buffer (package out_channel_pkg).
// Optional word checker in the top is enabled with `define OUT_CHECK_EN.
package out_channel_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int MEMORY_ELEMENT_WIDTH = 12;

  // Ceiling log2; pointer index width for a power-of-two depth.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/out_channel_buffer_fifo.sv
// out_fifo: word storage with wrap-bit pointers. A write into a full FIFO is
// only accepted when a read happens in the same cycle. Head is read
// combinationally from registered storage, so there is no write-to-read bypass.
module out_fifo
  import out_channel_pkg::*;
#(
  parameter int W = MEMORY_ELEMENT_WIDTH,
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         wr_req,
  input  logic [W-1:0] wr_data,
  input  logic         rd_req,
  output logic         wr_ok,
  output logic         rd_ok,
  output logic [W-1:0] rd_data,
  output logic         empty
);

  localparam int AW = clog2(N);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [N];
  logic         full;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_ok   = rd_req && !empty;
  assign wr_ok   = wr_req && (!full || rd_ok);
  // Drive zero when empty so the head is clean out of reset.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointers advance modulo 2*N; the extra MSB separates full from empty.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is data only; contents are meaningless until written.
  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/out_channel_buffer.sv
// out_channel_buffer: captures interpreter `out` words into a FIFO, streams
// them over valid/ready, and on prog_finished drains and reports
// finished/success. Define OUT_CHECK_EN to compare delivered words against
// the Expected table.
module out_channel_buffer
  import out_channel_pkg::*;
#(
  parameter int MemoryElementWidth = MEMORY_ELEMENT_WIDTH,
  parameter int NOut               = 8,
  parameter int NExpected          = 3,
  parameter logic [NExpected*MemoryElementWidth-1:0] Expected = {12'd1, 12'd0, 12'd3}
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [MemoryElementWidth-1:0] in_data,
  input  logic                          prog_finished,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MemoryElementWidth-1:0] out_data,
  output logic [15:0]                   word_count,
  output logic                          overflow,
  output logic                          finished,
  output logic                          success
);

  // Reject unusable configurations at elaboration.
  if ((NOut < 2) || ((NOut & (NOut - 1)) != 0) || (NExpected < 1) ||
      ($bits(Expected) != NExpected * MemoryElementWidth)) begin : g_bad_config
    $error("out_channel_buffer: invalid parameters");
  end

  state_t state;
  state_t state_next;
  logic   capture_req;
  logic   wr_ok;
  logic   xfer;
  logic   fifo_empty;
  logic   drop;
  logic   pass_now;

  assign capture_req = in_valid && (state == RUN);
  assign drop        = capture_req && !wr_ok;
  assign out_valid   = !fifo_empty;
  assign finished    = (state == DONE);

  out_fifo #(
    .W (MemoryElementWidth),
    .N (NOut)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_req  (capture_req),
    .wr_data (in_data),
    .rd_req  (out_ready),
    .wr_ok   (wr_ok),
    .rd_ok   (xfer),
    .rd_data (out_data),
    .empty   (fifo_empty)
  );

`ifdef OUT_CHECK_EN
  logic mismatch;
  int   exp_base;

  assign exp_base = int'(word_count) * MemoryElementWidth;
  assign pass_now = !overflow && !mismatch && (int'(word_count) == NExpected);

  // Sticky flag: any of the first NExpected delivered words differs from the table.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mismatch <= 1'b0;
    end else if (xfer && (int'(word_count) < NExpected) &&
                 (out_data != Expected[exp_base +: MemoryElementWidth])) begin
      mismatch <= 1'b1;
    end
  end
`else
  assign pass_now = !overflow;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_next;
  end

  // Next state: RUN until prog_finished, DRAIN until empty, then DONE forever.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (prog_finished) state_next = DRAIN;
      DRAIN:   if (fifo_empty)    state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = RUN;
    endcase
  end

  // Delivered-word counter (saturating), sticky overflow, and success latched on entering DONE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_count <= '0;
      overflow   <= 1'b0;
      success    <= 1'b0;
    end else begin
      if (xfer && (word_count != 16'hFFFF)) word_count <= word_count + 16'd1;
      if (drop) overflow <= 1'b1;
      if ((state == DRAIN) && fifo_empty) success <= pass_now;
    end
  end

endmodule

// File: tb/tb_out_channel_buffer.sv
// Bench for out_channel_buffer: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_out_channel_buffer;

  localparam int NOUT = 8;
  localparam int NEXP = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] in_data = '0;
  logic        prog_finished = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [11:0] out_data;
  logic [15:0] word_count;
  logic        overflow;
  logic        finished;
  logic        success;

  out_channel_buffer dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .prog_finished (prog_finished),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .word_count    (word_count),
    .overflow      (overflow),
    .finished      (finished),
    .success       (success)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a word queue and the run/drain/done phase.
  logic [11:0] mq[$];
  logic [11:0] dlog[$];
  logic [11:0] exp_tab [NEXP] = '{12'd3, 12'd0, 12'd1};
  int          m_count;
  bit          m_ovf;
  bit          m_mm;
  bit          m_succ;
  int          m_phase;

  always @(posedge clock or negedge reset) begin
    bit was_empty;
    bit xf;
    if (!reset) begin
      mq.delete();
      dlog.delete();
      m_count = 0;
      m_ovf   = 0;
      m_mm    = 0;
      m_succ  = 0;
      m_phase = 0;
    end else begin
      was_empty = (mq.size() == 0);
      xf = !was_empty && out_ready;
      if (xf) begin
        dlog.push_back(out_data);
        if (m_count < NEXP && mq[0] != exp_tab[m_count]) m_mm = 1;
        void'(mq.pop_front());
        if (m_count < 65535) m_count++;
      end
      if (m_phase == 0 && in_valid) begin
        if (mq.size() < NOUT) mq.push_back(in_data);
        else m_ovf = 1;
      end
      if (m_phase == 1 && was_empty) begin
        m_phase = 2;
`ifdef OUT_CHECK_EN
        m_succ = !m_ovf && !m_mm && (m_count == NEXP);
`else
        m_succ = !m_ovf;
`endif
      end else if (m_phase == 0 && prog_finished) begin
        m_phase = 1;
      end
    end
  end

  // Compare DUT against the model away from the active edge.
  always @(negedge clock) begin
    check("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) check("out_data", out_data, mq[0]);
    check("word_count", word_count, m_count);
    check("overflow", overflow, m_ovf);
    check("finished", finished, m_phase == 2);
    if (m_phase == 2) check("success", success, m_succ);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic emit(input logic [11:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_finished(input int budget);
    int n;
    n = 0;
    while (finished !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("finish_reached", finished, 1'b1);
  endtask

  task automatic finish_run();
    prog_finished = 1'b1;
    tick();
    prog_finished = 1'b0;
    wait_finished(60);
  endtask

  task automatic check_log(input string name, input logic [11:0] e[$]);
    check({name, "_len"}, dlog.size(), e.size());
    for (int i = 0; i < e.size() && i < dlog.size(); i++) check(name, dlog[i], e[i]);
  endtask

  initial begin
    logic [11:0] e[$];

    // Reset state
    reset = 1'b0;
    tick();
    tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_finished", finished, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_word_count", word_count, 16'd0);
    check("rst_success", success, 1'b0);
    reset = 1'b1;
    tick();

    // Basic run 3, 0, 1
    out_ready = 1'b1;
    emit(12'd3);
    check("t1_first_valid", out_valid, 1'b1);
    check("t1_first_data", out_data, 12'd3);
    emit(12'd0);
    emit(12'd1);
    finish_run();
    e = {12'd3, 12'd0, 12'd1};
    check_log("t1_log", e);
    check("t1_count", word_count, 16'd3);
    check("t1_success", success, 1'b1);
    // DONE ignores further inputs
    in_valid = 1'b1; in_data = 12'd77; prog_finished = 1'b1;
    tick();
    in_valid = 1'b0; prog_finished = 1'b0;
    tick();
    check("t1_done_hold", word_count, 16'd3);

    // Overflow: 9 words into 8 slots with no reads
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) emit(12'(i));
    out_ready = 1'b1;
    finish_run();
    e.delete();
    for (int i = 1; i <= 8; i++) e.push_back(12'(i));
    check_log("t2_log", e);
    check("t2_overflow", overflow, 1'b1);
    check("t2_success", success, 1'b0);
    check("t2_count", word_count, 16'd8);

    // Full plus simultaneous read and write
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) emit(12'(10 + i));
    out_ready = 1'b1;
    emit(12'd18);
    finish_run();
    e.delete();
    for (int i = 0; i < 9; i++) e.push_back(12'(10 + i));
    check_log("t3_log", e);
    check("t3_overflow", overflow, 1'b0);
    check("t3_count", word_count, 16'd9);
`ifdef OUT_CHECK_EN
    check("t3_success", success, 1'b0);
`else
    check("t3_success", success, 1'b1);
`endif

    // Drain with toggling ready; in_valid ignored during DRAIN
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) emit(12'(20 + i));
    prog_finished = 1'b1;
    tick();
    prog_finished = 1'b0;
    in_valid = 1'b1;
    in_data  = 12'd99;
    for (int n = 0; n < 40 && finished !== 1'b1; n++) begin
      out_ready = ~out_ready;
      tick();
    end
    in_valid = 1'b0;
    check("t4_finished", finished, 1'b1);
    check("t4_count", word_count, 16'd4);
    e = {12'd20, 12'd21, 12'd22, 12'd23};
    check_log("t4_log", e);

    // Mismatching stream; last word arrives with prog_finished
    do_reset();
    out_ready = 1'b1;
    emit(12'd3);
    emit(12'd5);
    in_valid = 1'b1; in_data = 12'd1; prog_finished = 1'b1;
    tick();
    in_valid = 1'b0; prog_finished = 1'b0;
    wait_finished(60);
    e = {12'd3, 12'd5, 12'd1};
    check_log("t5_log", e);
    check("t5_count", word_count, 16'd3);
`ifdef OUT_CHECK_EN
    check("t5_success", success, 1'b0);
`else
    check("t5_success", success, 1'b1);
`endif

    // Asynchronous reset with 5 words buffered
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) emit(12'(40 + i));
    in_valid = 1'b1; in_data = 12'd3;
    check("t6_pre_valid", out_valid, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    check("t6_async_valid", out_valid, 1'b0);
    check("t6_async_finished", finished, 1'b0);
    check("t6_async_overflow", overflow, 1'b0);
    check("t6_async_count", word_count, 16'd0);
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    emit(12'd3);
    emit(12'd0);
    emit(12'd1);
    finish_run();
    e = {12'd3, 12'd0, 12'd1};
    check_log("t6_log", e);
    check("t6_success", success, 1'b1);
    check("t6_count", word_count, 16'd3);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

endmodule
